// File: rtl/noc_pkg.sv
// Shared mesh NoC definitions: packet field positions and routing-header helpers.
package noc_pkg;

  localparam int unsigned DIR_X   = 0;
  localparam int unsigned DIR_Y   = 1;
  localparam int unsigned XHOP_LO = 2;
  localparam int unsigned HOP_MAX = 32;

  typedef struct packed {
    logic        east;
    logic        south;
    logic [31:0] x_hops;
    logic [31:0] y_hops;
  } hdr_t;

  // Ones in the low `count` positions, limited to `width` positions.
  function automatic logic [HOP_MAX-1:0] unary_hops(input int unsigned count,
                                                    input int unsigned width);
    logic [HOP_MAX-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < HOP_MAX; i++) begin
      if (i < count && i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic hdr_t encode_header(input int unsigned src,
                                         input int unsigned dst,
                                         input int unsigned cols);
    int unsigned sx, sy, dx, dy;
    hdr_t h;
    sx = src % cols;
    sy = src / cols;
    dx = dst % cols;
    dy = dst / cols;
    h.east   = (dx > sx);
    h.south  = (dy > sy);
    h.x_hops = (dx > sx) ? dx - sx : sx - dx;
    h.y_hops = (dy > sy) ? dy - sy : sy - dy;
    return h;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit to distinguish full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [0:WIDTH-1] push_data,
  input  logic             pop,
  output logic [0:WIDTH-1] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [0:WIDTH-1] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pe_packet_injector.sv
// PE-side mesh transmitter: encodes XY routing headers, queues packets and
// hands them to the router under valid/ready, dropping invalid destinations.
module pe_packet_injector
  import noc_pkg::*;
#(
  parameter int unsigned WIDTH     = 20,
  parameter int unsigned X_HOP_LOC = 4,
  parameter int unsigned Y_HOP_LOC = 7,
  parameter int unsigned NODE_NUM  = 0,
  parameter int unsigned MESH_COLS = 4,
  parameter int unsigned MESH_ROWS = 4,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ID_W-1:0]            req_dest,
  input  logic [WIDTH-Y_HOP_LOC-2:0] req_data,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic [0:WIDTH-1]           pkt_data,
  output logic                       drop_err,
  output logic [CNT_W-1:0]           inj_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int unsigned XW    = X_HOP_LOC - XHOP_LO + 1;
  localparam int unsigned YW    = Y_HOP_LOC - X_HOP_LOC;
  localparam int unsigned NODES = MESH_ROWS * MESH_COLS;

  hdr_t             hdr;
  logic [XW-1:0]    x_field;
  logic [YW-1:0]    y_field;
  logic [0:WIDTH-1] enc, head;
  logic             dest_ok, accept, push, pop, full, empty;

  // Hop fields are right-aligned: value bit k lands k positions left of the field end.
  always_comb begin
    hdr     = encode_header(NODE_NUM, 32'(req_dest), MESH_COLS);
    x_field = XW'(unary_hops(hdr.x_hops, XW));
    y_field = YW'(unary_hops(hdr.y_hops, YW));
    enc     = '0;
    enc[DIR_X] = hdr.east;
    enc[DIR_Y] = hdr.south;
    for (int unsigned k = 0; k < XW; k++) enc[X_HOP_LOC - k] = x_field[k];
    for (int unsigned k = 0; k < YW; k++) enc[Y_HOP_LOC - k] = y_field[k];
    enc[Y_HOP_LOC+1:WIDTH-1] = req_data;
  end

  assign dest_ok   = (32'(req_dest) != NODE_NUM) && (32'(req_dest) < NODES);
  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && dest_ok;
  assign pkt_valid = !empty;
  assign pop       = pkt_valid && pkt_ready;
  assign pkt_data  = empty ? '0 : head;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (enc),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
      inj_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      drop_err <= accept && !dest_ok;
      if (accept && !dest_ok) drop_cnt <= drop_cnt + CNT_W'(1);
      if (pop)                inj_cnt  <= inj_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pe_packet_injector.sv
// Randomized and directed bench for pe_packet_injector against a queue-based packet model.
module tb_pe_packet_injector;

  localparam int unsigned WIDTH     = 20;
  localparam int unsigned X_HOP_LOC = 4;
  localparam int unsigned Y_HOP_LOC = 7;
  localparam int unsigned NODE_NUM  = 5;
  localparam int unsigned MESH_COLS = 4;
  localparam int unsigned MESH_ROWS = 4;
  localparam int unsigned ID_W      = 5;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DW        = WIDTH - Y_HOP_LOC - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [ID_W-1:0]  req_dest = '0;
  logic [DW-1:0]    req_data = '0;
  logic             pkt_valid;
  logic             pkt_ready = 1'b1;
  logic [0:WIDTH-1] pkt_data;
  logic             drop_err;
  logic [CNT_W-1:0] inj_cnt, drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] q[$];
  int unsigned      m_inj, m_drop;
  bit               m_drop_flag, m_accepted;
  int unsigned      dests[6] = '{7, 0, 13, 4, 6, 15};

  always #5 clk = ~clk;

  pe_packet_injector #(
    .WIDTH     (WIDTH),
    .X_HOP_LOC (X_HOP_LOC),
    .Y_HOP_LOC (Y_HOP_LOC),
    .NODE_NUM  (NODE_NUM),
    .MESH_COLS (MESH_COLS),
    .MESH_ROWS (MESH_ROWS),
    .ID_W      (ID_W),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dest  (req_dest),
    .req_data  (req_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_data  (pkt_data),
    .drop_err  (drop_err),
    .inj_cnt   (inj_cnt),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packet as an integer: big-endian bit i has weight 2^(WIDTH-1-i).
  function automatic logic [WIDTH-1:0] model_pkt(input int unsigned dest, input logic [DW-1:0] data);
    int sx, sy, dx, dy, xh, yh;
    logic [WIDTH-1:0] v;
    sx = int'(NODE_NUM % MESH_COLS);
    sy = int'(NODE_NUM / MESH_COLS);
    dx = int'(dest % MESH_COLS);
    dy = int'(dest / MESH_COLS);
    xh = (dx > sx) ? dx - sx : sx - dx;
    yh = (dy > sy) ? dy - sy : sy - dy;
    v = WIDTH'(data);
    if (dx > sx) v[WIDTH-1] = 1'b1;
    if (dy > sy) v[WIDTH-2] = 1'b1;
    v |= WIDTH'(((1 << xh) - 1) << (WIDTH - 1 - X_HOP_LOC));
    v |= WIDTH'(((1 << yh) - 1) << (WIDTH - 1 - Y_HOP_LOC));
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_inj       = 0;
    m_drop      = 0;
    m_drop_flag = 0;
  endtask

  task automatic model_edge();
    bit          can_take, has_pkt;
    int unsigned d;
    can_take    = (q.size() < DEPTH);
    has_pkt     = (q.size() != 0);
    d           = 32'(req_dest);
    m_accepted  = req_valid && can_take;
    m_drop_flag = 0;
    if (has_pkt && pkt_ready) begin
      void'(q.pop_front());
      m_inj = (m_inj + 1) % (1 << CNT_W);
    end
    if (m_accepted) begin
      if (d != NODE_NUM && d < MESH_ROWS * MESH_COLS) q.push_back(model_pkt(d, req_data));
      else begin
        m_drop_flag = 1;
        m_drop      = (m_drop + 1) % (1 << CNT_W);
      end
    end
  endtask

  task automatic check_all();
    check("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
    check("pkt_valid", 32'(pkt_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("pkt_data", 32'(pkt_data), 32'(q[0]));
    check("drop_err", 32'(drop_err), 32'(m_drop_flag));
    check("inj_cnt", 32'(inj_cnt), m_inj);
    check("drop_cnt", 32'(drop_cnt), m_drop);
  endtask

  task automatic cycle(input bit v, input int unsigned d, input logic [DW-1:0] data, input bit rdy);
    req_valid = v;
    req_dest  = ID_W'(d);
    req_data  = data;
    pkt_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int idx, cyc;
    int unsigned inj_before;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_pkt_valid", 32'(pkt_valid), 0);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_pkt_data", 32'(pkt_data), 0);
    check("rst_inj_cnt", 32'(inj_cnt), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    check("rst_drop_err", 32'(drop_err), 0);

    // Single packets with known encodings.
    cycle(1, 7, 12'hABC, 1);
    check("hdr_dest7", 32'(pkt_data), 32'h98ABC);
    cycle(0, 0, '0, 1);
    check("inj_after_dest7", 32'(inj_cnt), 1);
    cycle(1, 0, 12'hABC, 1);
    check("hdr_dest0", 32'(pkt_data), 32'h09ABC);
    cycle(0, 0, '0, 1);
    cycle(1, 13, 12'hABC, 1);
    check("hdr_dest13", 32'(pkt_data), 32'h43ABC);
    cycle(0, 0, '0, 1);
    cycle(1, 4, 12'hABC, 1);
    cycle(0, 0, '0, 1);

    // Self-addressed and out-of-range requests are consumed and counted.
    cycle(1, 5, 12'hABC, 1);
    check("drop_self_pulse", 32'(drop_err), 1);
    cycle(1, 16, 12'hABC, 1);
    check("drop_range_cnt", 32'(drop_cnt), 2);
    cycle(1, 7, 12'hABC, 1);
    check("hdr_after_drop", 32'(pkt_data), 32'h98ABC);
    cycle(0, 0, '0, 1);

    // Stalled burst: four fill the queue, the rest wait for drain.
    inj_before = m_inj;
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 40) begin
      cycle(1, dests[idx], 12'hABC, cyc >= 8);
      if (m_accepted) idx++;
      cyc++;
    end
    check("burst_accepted", 32'(idx), 6);
    repeat (8) cycle(0, 0, '0, 1);
    check("burst_inj_cnt", 32'(inj_cnt), (inj_before + 6) % (1 << CNT_W));

    // Async reset with queued packets.
    for (int i = 0; i < 3; i++) cycle(1, dests[i], 12'h123, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_pkt_valid", 32'(pkt_valid), 0);
    check("mid_rst_pkt_data", 32'(pkt_data), 0);
    check("mid_rst_inj_cnt", 32'(inj_cnt), 0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(0, 0, '0, 1);

    // Random traffic, including counter wrap.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 3) != 0,
            ($urandom_range(0, 7) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 15),
            DW'($urandom), $urandom_range(0, 2) != 0);
    end
    repeat (6) cycle(0, 0, '0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
